// File: rtl/tone_freq_detector.sv
// Measures the rising-edge period of an asynchronous square-wave tone and
// classifies it as one of the notes C4..C5, with repeat-confirmation before reporting.
module tone_freq_detector #(
    parameter int unsigned T_CD        = 361374,
    parameter int unsigned T_DE        = 321950,
    parameter int unsigned T_EF        = 294857,
    parameter int unsigned T_FG        = 270723,
    parameter int unsigned T_GA        = 241187,
    parameter int unsigned T_AB        = 214850,
    parameter int unsigned T_BC        = 196816,
    parameter int unsigned PER_MAX     = 393686,
    parameter int unsigned PER_MIN     = 185468,
    parameter int unsigned PER_TIMEOUT = 524287,
    parameter int unsigned CONFIRM     = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        TONE_IN,
    output logic [18:0] PERIOD,
    output logic        PERIOD_STB,
    output logic [2:0]  NOTE,
    output logic        NOTE_VALID,
    output logic        NEW_NOTE
);

    typedef enum logic {S_IDLE, S_MEASURE} state_e;

    localparam logic [18:0] TH_CD   = 19'(T_CD);
    localparam logic [18:0] TH_DE   = 19'(T_DE);
    localparam logic [18:0] TH_EF   = 19'(T_EF);
    localparam logic [18:0] TH_FG   = 19'(T_FG);
    localparam logic [18:0] TH_GA   = 19'(T_GA);
    localparam logic [18:0] TH_AB   = 19'(T_AB);
    localparam logic [18:0] TH_BC   = 19'(T_BC);
    localparam logic [18:0] P_MAX   = 19'(PER_MAX);
    localparam logic [18:0] P_MIN   = 19'(PER_MIN);
    localparam logic [18:0] CNT_TO  = 19'(PER_TIMEOUT - 1);
    localparam logic [1:0]  CONF    = 2'(CONFIRM);

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q, dly_q;
    logic [18:0] cnt_q, cnt_d;
    logic [18:0] period_q, period_d;
    logic        stb_q, stb_d;
    logic [2:0]  note_q, note_d;
    logic        valid_q, valid_d;
    logic        new_q, new_d;
    logic [2:0]  cand_q, cand_d;
    logic [1:0]  match_q, match_d;

    logic        rise;
    logic        in_range;
    logic [2:0]  cls;
    logic [1:0]  m_new;
    logic [2:0]  c_new;

    assign rise = sync2_q & ~dly_q;

    // A period equal to a threshold falls through to the higher note.
    always_comb begin
        cls = 3'd7;
        if      (period_q > TH_CD) cls = 3'd0;
        else if (period_q > TH_DE) cls = 3'd1;
        else if (period_q > TH_EF) cls = 3'd2;
        else if (period_q > TH_FG) cls = 3'd3;
        else if (period_q > TH_GA) cls = 3'd4;
        else if (period_q > TH_AB) cls = 3'd5;
        else if (period_q > TH_BC) cls = 3'd6;
    end

    assign in_range = (period_q >= P_MIN) && (period_q <= P_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        stb_d    = 1'b0;
        note_d   = note_q;
        valid_d  = valid_q;
        new_d    = 1'b0;
        cand_d   = cand_q;
        match_d  = match_q;
        m_new    = match_q;
        c_new    = cand_q;

        if (!ENABLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            match_d = '0;
        end else begin
            // Match update for the period captured on the previous cycle.
            if (stb_q) begin
                if (!in_range) begin
                    match_d = '0;
                    valid_d = 1'b0;
                end else begin
                    if (cls == cand_q) begin
                        m_new = (match_q >= CONF) ? CONF : match_q + 2'd1;
                    end else begin
                        c_new = cls;
                        m_new = 2'd1;
                    end
                    cand_d  = c_new;
                    match_d = m_new;
                    if (m_new == CONF) begin
                        note_d  = c_new;
                        valid_d = 1'b1;
                        new_d   = !valid_q || (note_q != c_new);
                    end
                end
            end

            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (rise) state_d = S_MEASURE;
                end
                S_MEASURE: begin
                    if (rise) begin
                        cnt_d    = '0;
                        period_d = cnt_q + 19'd1;
                        stb_d    = 1'b1;
                    end else if (cnt_q == CNT_TO) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        match_d = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 19'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            dly_q    <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            stb_q    <= 1'b0;
            note_q   <= '0;
            valid_q  <= 1'b0;
            new_q    <= 1'b0;
            cand_q   <= '0;
            match_q  <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= TONE_IN;
            sync2_q  <= sync1_q;
            dly_q    <= sync2_q;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            stb_q    <= stb_d;
            note_q   <= note_d;
            valid_q  <= valid_d;
            new_q    <= new_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
        end
    end

    assign PERIOD     = period_q;
    assign PERIOD_STB = stb_q;
    assign NOTE       = note_q;
    assign NOTE_VALID = valid_q;
    assign NEW_NOTE   = new_q;

endmodule
